camellia_subkey_gen: RTL and testbench

Sequential subkey expander for Camellia-128. It sits between the key-schedule block that derives KA from KL and the round datapath. It latches KL and KA, then streams the 26 64-bit subkeys (kw1–kw4, k1–k18, ke1–ke4) one per handshake. The order is either encryption order or the swapped decryption order.

---
 rtl/camellia_subkey_gen.sv | 106 ++++++++++
 tb/tb_camellia_subkey_gen.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/camellia_subkey_gen.sv
// camellia_subkey_gen: latches KL/KA and streams the 26 Camellia-128 subkeys one per handshake
module camellia_subkey_gen (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic         decrypt,
  input  logic [127:0] KL,
  input  logic [127:0] KA,
  output logic         key_ready,
  output logic         subkey_valid,
  input  logic         subkey_ready,
  output logic [63:0]  subkey,
  output logic [4:0]   subkey_idx,
  output logic [1:0]   subkey_type,
  output logic         subkey_last,
  output logic         done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [127:0] kl_q, ka_q, kl_s, ka_s;
  logic         dec_q, dec_s, load, use_ka;
  logic [4:0]   nidx, eidx;
  logic [6:0]   rot;
  logic [1:0]   typ;
  logic [63:0]  word;

  function automatic logic [63:0] half(input logic [127:0] k, input logic [6:0] n, input logic hi);
    logic [127:0] r;
    r = (k << n) | (k >> (8'd128 - {1'b0, n}));
    return hi ? r[127:64] : r[63:0];
  endfunction

  assign key_ready    = state == IDLE;
  assign subkey_valid = state == RUN;
  assign done         = state == DONE;
  assign kl_s  = key_ready ? KL : kl_q;
  assign ka_s  = key_ready ? KA : ka_q;
  assign dec_s = key_ready ? decrypt : dec_q;
  assign load  = (key_ready && start) || (subkey_valid && subkey_ready && !subkey_last);
  assign nidx  = key_ready ? 5'd0 : subkey_idx + 5'd1;
  assign eidx  = !dec_s ? nidx : nidx < 5'd2 ? nidx + 5'd24 : nidx > 5'd23 ? nidx - 5'd24 : 5'd25 - nidx;
  assign typ   = (nidx < 5'd2 || nidx > 5'd23) ? 2'd0 :
                 (nidx == 5'd8 || nidx == 5'd9 || nidx == 5'd16 || nidx == 5'd17) ? 2'd2 : 2'd1;
  assign word  = half(use_ka ? ka_s : kl_s, rot, !eidx[0]);

  // source key and rotation for each encryption-order slot
  always_comb begin
    use_ka = 1'b0;
    rot    = 7'd0;
    case (eidx)
      5'd2, 5'd3:   use_ka = 1'b1;
      5'd4, 5'd5:   rot = 7'd15;
      5'd6, 5'd7:   begin use_ka = 1'b1; rot = 7'd15; end
      5'd8, 5'd9:   begin use_ka = 1'b1; rot = 7'd30; end
      5'd10, 5'd11: rot = 7'd45;
      5'd12:        begin use_ka = 1'b1; rot = 7'd45; end
      5'd13:        rot = 7'd60;
      5'd14, 5'd15: begin use_ka = 1'b1; rot = 7'd60; end
      5'd16, 5'd17: rot = 7'd77;
      5'd18, 5'd19: rot = 7'd94;
      5'd20, 5'd21: begin use_ka = 1'b1; rot = 7'd94; end
      5'd22, 5'd23: rot = 7'd111;
      5'd24, 5'd25: begin use_ka = 1'b1; rot = 7'd111; end
      default:      rot = 7'd0;
    endcase
  end

  // state register
  always_ff @(posedge CLK or negedge RST)
    if (!RST) state <= IDLE;
    else state <= state_n;

  // next state: accept start when idle, leave RUN on the last handshake
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? RUN : IDLE;
      RUN:     state_n = (subkey_ready && subkey_last) ? DONE : RUN;
      default: state_n = IDLE;
    endcase
  end

  // key latch and registered output word for the upcoming step
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      kl_q        <= '0;
      ka_q        <= '0;
      dec_q       <= 1'b0;
      subkey      <= '0;
      subkey_idx  <= '0;
      subkey_type <= '0;
      subkey_last <= 1'b0;
    end else begin
      if (key_ready && start) begin
        kl_q  <= KL;
        ka_q  <= KA;
        dec_q <= decrypt;
      end
      if (load) begin
        subkey      <= word;
        subkey_idx  <= nidx;
        subkey_type <= typ;
        subkey_last <= nidx == 5'd25;
      end
    end
endmodule

// File: tb/tb_camellia_subkey_gen.sv
// tb_camellia_subkey_gen: directed checks of the Camellia-128 subkey stream
module tb_camellia_subkey_gen;
  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, decrypt = 1'b0, subkey_ready = 1'b0;
  logic [127:0] KL = '0, KA = '0;
  logic         key_ready, subkey_valid, subkey_last, done;
  logic [63:0]  subkey;
  logic [4:0]   subkey_idx;
  logic [1:0]   subkey_type;
  int total = 0, bad = 0;
  int rot   [26] = '{0,0,0,0,15,15,15,15,30,30,45,45,45,60,60,60,77,77,94,94,94,94,111,111,111,111};
  bit srcka [26] = '{0,0,1,1,0,0,1,1,1,1,0,0,1,0,1,1,0,0,0,0,1,1,0,0,1,1};
  int dord  [26] = '{24,25,23,22,21,20,19,18,17,16,15,14,13,12,11,10,9,8,7,6,5,4,3,2,0,1};
  logic [1:0] t0 [26];
  logic [1:0] t1 [26];

  camellia_subkey_gen dut (
    .CLK(clk), .RST(rst_n), .start(start), .decrypt(decrypt), .KL(KL), .KA(KA),
    .key_ready(key_ready), .subkey_valid(subkey_valid), .subkey_ready(subkey_ready),
    .subkey(subkey), .subkey_idx(subkey_idx), .subkey_type(subkey_type),
    .subkey_last(subkey_last), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mdl(input logic [127:0] kl, input logic [127:0] ka, input bit dec, input int p);
    int e;
    logic [255:0] d;
    logic [127:0] r;
    e = dec ? dord[p] : p;
    d = srcka[e] ? {ka, ka} : {kl, kl};
    r = 128'(d >> (128 - rot[e]));
    return (e % 2 == 0) ? r[127:64] : r[63:0];
  endfunction

  function automatic logic [63:0] hand(input bit dec, input int p);
    if (!dec)
      case (p)
        1:  return 64'h1;
        5:  return 64'h8000;
        11: return 64'h0000_2000_0000_0000;
        13: return 64'h1000_0000_0000_0000;
        16: return 64'h2000;
        18: return 64'h4000_0000;
        22: return 64'h0000_8000_0000_0000;
        default: return 64'h0;
      endcase
    case (p)
      3:  return 64'h0000_8000_0000_0000;
      7:  return 64'h4000_0000;
      9:  return 64'h2000;
      12: return 64'h1000_0000_0000_0000;
      14: return 64'h0000_2000_0000_0000;
      20: return 64'h8000;
      25: return 64'h1;
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [1:0] typ(input int p);
    return (p < 2 || p > 23) ? 2'd0 : (p == 8 || p == 9 || p == 16 || p == 17) ? 2'd2 : 2'd1;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_kready"}, 64'(key_ready), 64'd1);
    chk({tag, "_valid"}, 64'(subkey_valid), 64'd0);
    chk({tag, "_word"}, subkey, 64'd0);
    chk({tag, "_idx"}, 64'(subkey_idx), 64'd0);
    chk({tag, "_type"}, 64'(subkey_type), 64'd0);
    chk({tag, "_last"}, 64'(subkey_last), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  task automatic run(input bit dec, input logic [127:0] kl, input logic [127:0] ka,
                     input bit bp, input bit hnd, input bit mess);
    logic [63:0] e;
    int n, cyc;
    start = 1'b1; decrypt = dec; KL = kl; KA = ka; subkey_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; cyc = 0;
    while (n < 26 && cyc < 400) begin
      e = hnd ? hand(dec, n) : mdl(kl, ka, dec, n);
      chk("valid", 64'(subkey_valid), 64'd1);
      chk("kready_run", 64'(key_ready), 64'd0);
      chk("idx", 64'(subkey_idx), 64'(n));
      chk("word", subkey, e);
      chk("type", 64'(subkey_type), 64'(typ(n)));
      chk("last", 64'(subkey_last), 64'(n == 25));
      chk("done_run", 64'(done), 64'd0);
      if (mess && n == 10) begin start = 1'b1; KL = ~kl; KA = ~ka; end
      else start = 1'b0;
      subkey_ready = bp ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      if (subkey_ready) n++;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("accepted", 64'(n), 64'd26);
    chk("valid_end", 64'(subkey_valid), 64'd0);
    chk("done_pulse", 64'(done), 64'd1);
    @(negedge clk);
    chk("done_off", 64'(done), 64'd0);
    chk("kready_end", 64'(key_ready), 64'd1);
  endtask

  initial begin
    logic [127:0] kl, ka;
    int s, g, cyc;
    bit gapped, fin;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("idle");

    run(1'b0, 128'h1, 128'h0, 1'b0, 1'b1, 1'b0);
    run(1'b1, 128'h1, 128'h0, 1'b0, 1'b1, 1'b0);

    kl = {$urandom, $urandom, $urandom, $urandom};
    ka = {$urandom, $urandom, $urandom, $urandom};
    run(1'b0, kl, ka, 1'b1, 1'b0, 1'b0);
    run(1'b1, kl, ka, 1'b1, 1'b0, 1'b0);
    run(1'b0, kl ^ 128'h55, ka, 1'b0, 1'b0, 1'b1);

    start = 1'b1; decrypt = 1'b0; KL = kl; KA = ka; subkey_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (subkey_idx != 5'd7 && cyc < 40) begin @(negedge clk); cyc++; end
    chk("rst_at_idx", 64'(subkey_idx), 64'd7);
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    @(negedge clk);
    chk_reset("midrst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    run(1'b1, ka, kl, 1'b0, 1'b0, 1'b0);

    start = 1'b1; decrypt = 1'b0; KL = kl; KA = ka; subkey_ready = 1'b1;
    s = 0; g = 0; cyc = 0; gapped = 1'b0; fin = 1'b0;
    while (!fin && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (s == 1) g++;
      if (done && s == 0) begin s = 1; g = 0; decrypt = 1'b1; end
      if (subkey_valid) begin
        if (subkey !== mdl(kl, ka, s[0], int'(subkey_idx))) chk("b2b_word", subkey, mdl(kl, ka, s[0], int'(subkey_idx)));
        if (s == 0) t0[subkey_idx] = subkey_type;
        else t1[subkey_idx] = subkey_type;
        if (s == 1 && subkey_idx == 5'd0 && !gapped) begin
          chk("b2b_gap", 64'(g), 64'd2);
          gapped = 1'b1;
        end
        if (s == 1 && subkey_last) begin fin = 1'b1; start = 1'b0; end
      end
    end
    chk("b2b_finished", 64'(fin), 64'd1);
    for (int i = 0; i < 26; i++) begin
      chk("b2b_type_enc", 64'(t0[i]), 64'(typ(i)));
      chk("b2b_type_dec", 64'(t1[i]), 64'(typ(i)));
    end
    repeat (3) @(negedge clk);
    chk("b2b_idle", 64'(key_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
